mem_stage: RTL
==============

Name: mem_stage

Overview:
- Memory-access stage of the 5-stage MIPS pipeline. Sits directly downstream of the EX/MEM pipeline register and consumes its MEM_* outputs.
- Performs data RAM loads and stores, and hosts the memory-mapped timer, LED and systick peripherals.
- Registers everything the write-back stage needs into MEM/WB pipeline registers (WB_*).

Parameters:
- RAM_DEPTH, 256, number of 32-bit words in the data RAM (power of two).
- RAM_AW, 8, log2(RAM_DEPTH); word-index width.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  synchronous active-high reset
- MEM_MemRead  in  1  load enable
- MEM_MemWrite  in  1  store enable
- MEM_RegWrite  in  1  register-file write enable, passed to WB
- MEM_MemtoReg  in  2  write-back select: 0 ALU result, 1 memory data, 2 PC+4
- MEM_Write_register  in  5  destination register number
- MEM_ALUout  in  32  effective address / ALU result
- MEM_MUX1  in  32  store data
- MEM_PC4  in  32  PC+4 of the instruction
- MEM_ReadData  out  32  combinational load data, for the forwarding unit
- WB_RegWrite  out  1  registered MEM_RegWrite
- WB_MemtoReg  out  2  registered MEM_MemtoReg
- WB_Write_register  out  5  registered destination register
- WB_WriteData  out  32  registered final write-back value (selected by MemtoReg)
- irq  out  1  timer interrupt request
- leds  out  8  LED register

Behaviour:
- Address decode uses MEM_ALUout (A).
  - RAM region: A[31:30]==2'b00 and A[31:2] < RAM_DEPTH. Index = A[RAM_AW+1:2].
  - Peripheral registers: TH 0x40000000, TL 0x40000004, TCON 0x40000008, LED 0x4000000C, SYSTICK 0x40000014.
  - Any other address is unmapped: reads return 0, writes are ignored.
- Alignment: A[1:0]!=0 is misaligned. On a misaligned access, stores are suppressed and loads return 0.
- Reads are combinational:
  - MEM_ReadData = decoded value when MEM_MemRead=1, else 0.
  - TCON reads as {29'b0, TCON[2:0]}; LED reads as {24'b0, leds}.
- Writes are synchronous on the rising clk edge when MEM_MemWrite=1.
  - If MemRead and MemWrite are both 1 in the same cycle, the read returns the pre-write value.
- Register writability:
  - TH: writable.
  - TL: writable.
  - TCON: bits [2:0] writable.
  - LED: bits [7:0] writable.
  - SYSTICK: read-only; writes ignored.
- Timer, evaluated every cycle when TCON[0]=1:
  - If TL==32'hFFFFFFFF: TL<=TH, and TCON[2]<=1 if TCON[1]=1.
  - Otherwise TL<=TL+1.
  - A CPU write to TL or TCON in the same cycle overrides the hardware update of that register. A CPU write of TCON[2]=0 clears the interrupt status.
  - irq = TCON[1] & TCON[2] (combinational from registers).
- SYSTICK increments by 1 every cycle and wraps from 0xFFFFFFFF to 0.
- MEM/WB register, latency 1:
  - WB_RegWrite, WB_MemtoReg and WB_Write_register capture their MEM_* inputs.
  - WB_WriteData captures the value selected by MemtoReg: 0 gives MEM_ALUout, 1 gives MEM_ReadData, 2 gives MEM_PC4, 3 gives 0.
- Reset (synchronous, any cycle including mid-operation):
  - All WB_* outputs go to 0; TH, TL, TCON, leds and SYSTICK go to 0; irq goes to 0.
  - RAM contents are not cleared.
  - A store presented in the same cycle as reset is dropped for peripherals but still written to RAM. Reset has priority for every reset-cleared register.
- No stall or flush inputs. The upstream register bubbles by driving its control bits to 0.

Test Plan:
- Store then load: MemWrite at A=0x10 with data 0xDEADBEEF; next cycle MemRead at A=0x10 with MemtoReg=1 -> MEM_ReadData=0xDEADBEEF combinationally; WB_WriteData=0xDEADBEEF one cycle later.
- Misaligned and unmapped: store to 0x11 and to 0x20000000, then load from 0x10 (prior value 0x1) -> reads 0x1; load from 0x20000000 -> 0.
- Timer wrap: TH=0xFFFFFFFD, TL=0xFFFFFFFE, TCON=3 -> TL reads 0xFFFFFFFF after 1 cycle and 0xFFFFFFFD after 2 cycles; TCON[2]=1; irq=1. Then write TCON=3 -> irq=0.
- Simultaneous TL write and count: timer enabled, write TL=0x5 in the same cycle -> TL=0x5, then 0x6 on the next cycle.
- Write-back select: MemtoReg=2, PC4=0x00400008 -> WB_WriteData=0x00400008. MemtoReg=0, ALUout=0x7 -> WB_WriteData=0x7. Write to LED 0xA5 -> leds=0xA5; SYSTICK write is ignored.
- Reset mid-run: assert reset with timer running and leds=0xA5 -> after that edge all WB_*, leds, TL, TCON and irq are 0. A RAM word written before reset still reads back unchanged after reset.

Source files
------------

// File: rtl/mem_stage.sv
`default_nettype none
// ============================================================================
// Module   : mem_stage
// Purpose  : Memory-access stage of a 5-stage MIPS pipeline. Performs data RAM
//            loads/stores, hosts the memory-mapped timer (TH/TL/TCON), LED
//            and SYSTICK registers, and holds the MEM/WB pipeline registers.
// Ports    : clk, reset             - clock, synchronous active-high reset
//            MEM_MemRead/MemWrite   - load / store enables
//            MEM_RegWrite/MemtoReg/ - control passed on to write-back
//            MEM_Write_register
//            MEM_ALUout             - effective address / ALU result
//            MEM_MUX1               - store data
//            MEM_PC4                - PC+4 of the instruction
//            MEM_ReadData           - combinational load data (forwarding)
//            WB_*                   - MEM/WB pipeline register outputs
//            irq                    - timer interrupt request
//            leds                   - LED register
// Revision : 1.0 - initial release
// ============================================================================
module mem_stage #(
    parameter int RAM_DEPTH = 256,
    parameter int RAM_AW    = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MEM_MemRead,
    input  logic        MEM_MemWrite,
    input  logic        MEM_RegWrite,
    input  logic [1:0]  MEM_MemtoReg,
    input  logic [4:0]  MEM_Write_register,
    input  logic [31:0] MEM_ALUout,
    input  logic [31:0] MEM_MUX1,
    input  logic [31:0] MEM_PC4,
    output logic [31:0] MEM_ReadData,
    output logic        WB_RegWrite,
    output logic [1:0]  WB_MemtoReg,
    output logic [4:0]  WB_Write_register,
    output logic [31:0] WB_WriteData,
    output logic        irq,
    output logic [7:0]  leds
);

    localparam logic [31:0] c_ADDR_TH      = 32'h4000_0000;
    localparam logic [31:0] c_ADDR_TL      = 32'h4000_0004;
    localparam logic [31:0] c_ADDR_TCON    = 32'h4000_0008;
    localparam logic [31:0] c_ADDR_LED     = 32'h4000_000C;
    localparam logic [31:0] c_ADDR_SYSTICK = 32'h4000_0014;

    logic [31:0] r_ram [0:RAM_DEPTH-1];
    logic [31:0] r_th;
    logic [31:0] r_tl;
    logic [2:0]  r_tcon;
    logic [7:0]  r_leds;
    logic [31:0] r_systick;

    logic              w_aligned;
    logic              w_ram_hit;
    logic [RAM_AW-1:0] w_idx;
    logic              w_wr;
    logic              w_wr_ram;
    logic              w_wr_th;
    logic              w_wr_tl;
    logic              w_wr_tcon;
    logic              w_wr_led;
    logic              w_tl_max;
    logic [31:0]       w_rd_val;
    logic [31:0]       w_wb_data;

    // ------------------------------------------------------------------
    // Address decode. With a power-of-two depth, "word index < RAM_DEPTH"
    // reduces to all address bits above the index being zero, which also
    // covers the A[31:30]==0 region condition.
    // ------------------------------------------------------------------
    assign w_aligned = (MEM_ALUout[1:0] == 2'b00);
    assign w_ram_hit = (MEM_ALUout[31:RAM_AW+2] == '0);
    assign w_idx     = MEM_ALUout[RAM_AW+1:2];

    assign w_wr      = MEM_MemWrite & w_aligned;
    assign w_wr_ram  = w_wr & w_ram_hit;
    assign w_wr_th   = w_wr & (MEM_ALUout == c_ADDR_TH);
    assign w_wr_tl   = w_wr & (MEM_ALUout == c_ADDR_TL);
    assign w_wr_tcon = w_wr & (MEM_ALUout == c_ADDR_TCON);
    assign w_wr_led  = w_wr & (MEM_ALUout == c_ADDR_LED);

    assign w_tl_max  = (r_tl == 32'hFFFF_FFFF);

    // ------------------------------------------------------------------
    // Combinational read path; returns the pre-write value when a store
    // to the same location happens in the same cycle.
    // ------------------------------------------------------------------
    always_comb begin
        w_rd_val = 32'd0;
        if (w_aligned) begin
            if (w_ram_hit) begin
                w_rd_val = r_ram[w_idx];
            end else begin
                case (MEM_ALUout)
                    c_ADDR_TH:      w_rd_val = r_th;
                    c_ADDR_TL:      w_rd_val = r_tl;
                    c_ADDR_TCON:    w_rd_val = {29'd0, r_tcon};
                    c_ADDR_LED:     w_rd_val = {24'd0, r_leds};
                    c_ADDR_SYSTICK: w_rd_val = r_systick;
                    default:        w_rd_val = 32'd0;
                endcase
            end
        end
    end

    assign MEM_ReadData = MEM_MemRead ? w_rd_val : 32'd0;

    // RAM is deliberately outside the reset domain: its contents survive
    // reset and a store coinciding with reset still lands.
    always_ff @(posedge clk) begin
        if (w_wr_ram) begin
            r_ram[w_idx] <= MEM_MUX1;
        end
    end

    // ------------------------------------------------------------------
    // Peripherals. A CPU write to TL or TCON takes precedence over the
    // timer's own update of that register in the same cycle.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_th      <= 32'd0;
            r_tl      <= 32'd0;
            r_tcon    <= 3'd0;
            r_leds    <= 8'd0;
            r_systick <= 32'd0;
        end else begin
            r_systick <= r_systick + 32'd1;

            if (w_wr_th) begin
                r_th <= MEM_MUX1;
            end

            if (w_wr_tl) begin
                r_tl <= MEM_MUX1;
            end else if (r_tcon[0]) begin
                r_tl <= w_tl_max ? r_th : (r_tl + 32'd1);
            end

            if (w_wr_tcon) begin
                r_tcon <= MEM_MUX1[2:0];
            end else if (r_tcon[0] && w_tl_max && r_tcon[1]) begin
                r_tcon[2] <= 1'b1;
            end

            if (w_wr_led) begin
                r_leds <= MEM_MUX1[7:0];
            end
        end
    end

    assign irq  = r_tcon[1] & r_tcon[2];
    assign leds = r_leds;

    // ------------------------------------------------------------------
    // MEM/WB pipeline register
    // ------------------------------------------------------------------
    always_comb begin
        w_wb_data = 32'd0;
        case (MEM_MemtoReg)
            2'd0:    w_wb_data = MEM_ALUout;
            2'd1:    w_wb_data = MEM_ReadData;
            2'd2:    w_wb_data = MEM_PC4;
            default: w_wb_data = 32'd0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            WB_RegWrite       <= 1'b0;
            WB_MemtoReg       <= 2'd0;
            WB_Write_register <= 5'd0;
            WB_WriteData      <= 32'd0;
        end else begin
            WB_RegWrite       <= MEM_RegWrite;
            WB_MemtoReg       <= MEM_MemtoReg;
            WB_Write_register <= MEM_Write_register;
            WB_WriteData      <= w_wb_data;
        end
    end

endmodule
`default_nettype wire
